// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline constants: datapath width, the canonical NOP and the
// major opcodes decode dispatches on.
package riscv_pkg;

   localparam int XLEN = 32;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   localparam logic [6:0] OPC_R      = 7'b0110011;
   localparam logic [6:0] OPC_I_ALU  = 7'b0010011;
   localparam logic [6:0] OPC_I_LOAD = 7'b0000011;
   localparam logic [6:0] OPC_I_JALR = 7'b1100111;
   localparam logic [6:0] OPC_U_LUI  = 7'b0110111;
   localparam logic [6:0] OPC_U_AUI  = 7'b0010111;
   localparam logic [6:0] OPC_B      = 7'b1100011;
   localparam logic [6:0] OPC_J      = 7'b1101111;
   localparam logic [6:0] OPC_S      = 7'b0100011;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush. Holds decode-bound {pc, instr} pairs and,
// at a narrower width, the addresses of requests still in flight.
module fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int W = 64,
   localparam int CW = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic [W-1:0]  push_data,
   input  logic          pop,
   input  logic          flush,
   output logic [W-1:0]  head,
   output logic [CW-1:0] count,
   output logic          empty
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_r [DEPTH];
   logic [AW-1:0] rd_ptr_r;
   logic [AW-1:0] wr_ptr_r;
   logic [CW-1:0] count_r;
   logic          push_ok_s;
   logic          pop_ok_s;

   // Pointers wrap explicitly so non-power-of-two depths work.
   function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? {AW{1'b0}} : p + AW'(1);
   endfunction

   always_comb begin
      pop_ok_s  = pop && (count_r != {CW{1'b0}});
      push_ok_s = push && ((count_r != CW'(DEPTH)) || pop_ok_s);
   end

   always_ff @(posedge clk) begin
      if (push_ok_s && !flush) mem_r[wr_ptr_r] <= push_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr_r <= {AW{1'b0}};
         wr_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else if (flush) begin
         rd_ptr_r <= {AW{1'b0}};
         wr_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         if (push_ok_s) wr_ptr_r <= bump(wr_ptr_r);
         if (pop_ok_s) rd_ptr_r <= bump(rd_ptr_r);
         count_r <= count_r + CW'(push_ok_s) - CW'(pop_ok_s);
      end
   end

   assign head  = mem_r[rd_ptr_r];
   assign count = count_r;
   assign empty = (count_r == {CW{1'b0}});

endmodule

// File: rtl/fetch.sv
// Instruction fetch: PC, credit-limited in-order memory requests, response
// buffering toward decode, and redirect handling with stale-response dropping.
module fetch
   import riscv_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
   parameter int              DEPTH    = 2
) (
   input  logic            req,
   input  logic            reset,
   input  logic            stall_in,
   input  logic            redirect_in,
   input  logic [XLEN-1:0] redirect_pc_in,
   output logic            imem_valid_out,
   output logic [XLEN-1:0] imem_addr_out,
   input  logic            imem_ready_in,
   input  logic            imem_rvalid_in,
   input  logic [XLEN-1:0] imem_rdata_in,
   output logic            valid_out,
   output logic [XLEN-1:0] instr_out,
   output logic [XLEN-1:0] pc_out
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [XLEN-1:0]   pc_r;
   logic [XLEN-1:0]   last_pc_r;
   logic [CW-1:0]     drop_cnt_r;
   logic [CW-1:0]     outstanding_s;
   logic [CW-1:0]     occupancy_s;
   logic [CW:0]       credit_sum_s;
   logic              fifo_empty_s;
   logic              aq_empty_s;
   logic [XLEN-1:0]   aq_head_s;
   fetch_entry_t      fifo_head_s;
   fetch_entry_t      fifo_push_s;
   logic              pop_s;
   logic              fifo_pop_s;
   logic              accept_s;
   logic              ret_s;
   logic              keep_s;

   // A pop frees its credit in the same cycle; redirect or reset blocks issue.
   always_comb begin
      pop_s          = !fifo_empty_s && !stall_in;
      credit_sum_s   = {1'b0, outstanding_s} + {1'b0, occupancy_s} - (CW+1)'(pop_s);
      imem_valid_out = !reset && !redirect_in && (credit_sum_s < (CW+1)'(DEPTH));
      accept_s       = imem_valid_out && imem_ready_in;
      ret_s          = imem_rvalid_in && !aq_empty_s;
      keep_s         = ret_s && !redirect_in && (drop_cnt_r == {CW{1'b0}});
      fifo_pop_s     = pop_s && !redirect_in;
      fifo_push_s    = '{pc: aq_head_s, instr: imem_rdata_in};
   end

   // The address queue count doubles as the outstanding-request counter.
   fetch_fifo #(.DEPTH(DEPTH), .W(XLEN)) u_addr_q (
      .clk       (req),
      .reset     (reset),
      .push      (accept_s),
      .push_data (pc_r),
      .pop       (ret_s),
      .flush     (1'b0),
      .head      (aq_head_s),
      .count     (outstanding_s),
      .empty     (aq_empty_s)
   );

   fetch_fifo #(.DEPTH(DEPTH), .W(2*XLEN)) u_instr_q (
      .clk       (req),
      .reset     (reset),
      .push      (keep_s),
      .push_data (fifo_push_s),
      .pop       (fifo_pop_s),
      .flush     (redirect_in),
      .head      (fifo_head_s),
      .count     (occupancy_s),
      .empty     (fifo_empty_s)
   );

   always_ff @(posedge req or posedge reset) begin
      if (reset) begin
         pc_r <= RESET_PC;
      end else if (redirect_in) begin
         pc_r <= {redirect_pc_in[XLEN-1:2], 2'b00};
      end else if (accept_s) begin
         pc_r <= pc_r + 32'd4;
      end
   end

   // Everything still in flight at a redirect belongs to the wrong path.
   always_ff @(posedge req or posedge reset) begin
      if (reset) begin
         drop_cnt_r <= {CW{1'b0}};
      end else if (redirect_in) begin
         drop_cnt_r <= outstanding_s + CW'(accept_s) - CW'(ret_s);
      end else if (ret_s && (drop_cnt_r != {CW{1'b0}})) begin
         drop_cnt_r <= drop_cnt_r - CW'(1);
      end
   end

   always_ff @(posedge req or posedge reset) begin
      if (reset) begin
         last_pc_r <= RESET_PC;
      end else if (fifo_pop_s) begin
         last_pc_r <= fifo_head_s.pc;
      end
   end

   assign imem_addr_out = pc_r;
   assign valid_out     = !fifo_empty_s;
   assign instr_out     = fifo_empty_s ? NOP_INSTR : fifo_head_s.instr;
   assign pc_out        = fifo_empty_s ? last_pc_r : fifo_head_s.pc;

endmodule

// File: tb/tb_fetch.sv
// Randomized bench for fetch: an in-order memory model drives responses, and
// a scoreboard of expected {pc, instr} in program order checks decode output.
module tb_fetch;
   import riscv_pkg::*;

   localparam logic [31:0] RPC = 32'h0000_0100;
   localparam int          D   = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        stall_in = 1'b0;
   logic        redirect_in = 1'b0;
   logic [31:0] redirect_pc_in = 32'h0;
   logic        imem_ready_in = 1'b0;
   logic        imem_rvalid_in = 1'b0;
   logic [31:0] imem_rdata_in = 32'h0;
   logic        imem_valid_out;
   logic [31:0] imem_addr_out;
   logic        valid_out;
   logic [31:0] instr_out;
   logic [31:0] pc_out;

   fetch #(.RESET_PC(RPC), .DEPTH(D)) dut (
      .req            (clk),
      .reset          (reset),
      .stall_in       (stall_in),
      .redirect_in    (redirect_in),
      .redirect_pc_in (redirect_pc_in),
      .imem_valid_out (imem_valid_out),
      .imem_addr_out  (imem_addr_out),
      .imem_ready_in  (imem_ready_in),
      .imem_rvalid_in (imem_rvalid_in),
      .imem_rdata_in  (imem_rdata_in),
      .valid_out      (valid_out),
      .instr_out      (instr_out),
      .pc_out         (pc_out)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          n_pops = 0;
   int          cyc = 0;
   logic [31:0] mem_q[$];
   logic [63:0] exp_q[$];
   logic [31:0] req_pc = RPC;
   bit          zw = 1'b0;
   bit          full_chk = 1'b0;
   bit          resp_en = 1'b1;
   int          rdy_pct = 100;
   int          rsp_pct = 100;
   int          stl_pct = 0;
   int          rdr_pct = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [11:0] imm;
      imm = a[13:2] ^ a[25:14] ^ {6'b0, a[31:26]};
      return {imm, 5'd1, 3'b000, 5'd1, 7'b0010011};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock of stimulus; the memory answers the oldest accepted address.
   task automatic cycle();
      @(posedge clk);
      #1;
      stall_in      = ($urandom_range(99) < stl_pct);
      imem_ready_in = ($urandom_range(99) < rdy_pct);
      redirect_in   = 1'b0;
      if (!reset && resp_en && mem_q.size() > 0 && $urandom_range(99) < rsp_pct) begin
         imem_rvalid_in = 1'b1;
         imem_rdata_in  = mem_word(mem_q.pop_front());
      end else begin
         imem_rvalid_in = 1'b0;
         imem_rdata_in  = $urandom;
      end
      if (!reset && $urandom_range(99) < rdr_pct) begin
         redirect_in    = 1'b1;
         redirect_pc_in = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(15)) : $urandom;
      end
   endtask

   task automatic do_redirect(input logic [31:0] target, input logic st);
      cycle();
      redirect_in    = 1'b1;
      redirect_pc_in = target;
      stall_in       = st;
   endtask

   initial begin
      reset = 1'b1;
      repeat (3) cycle();
      reset = 1'b0;
      zw    = 1'b1;
      repeat (14) cycle();
      zw = 1'b0;
      stl_pct = 100;
      repeat (3) cycle();
      full_chk = 1'b1;
      repeat (3) cycle();
      full_chk = 1'b0;
      stl_pct  = 0;
      repeat (6) cycle();
      resp_en = 1'b0;
      repeat (3) cycle();
      do_redirect(32'h0000_2002, 1'b0);
      resp_en = 1'b1;
      repeat (8) cycle();
      do_redirect(32'h0000_3000, 1'b1);
      repeat (6) cycle();
      do_redirect(32'hFFFF_FFF8, 1'b0);
      repeat (8) cycle();
      stl_pct = 100;
      repeat (3) cycle();
      full_chk = 1'b1;
      repeat (2) cycle();
      full_chk = 1'b0;
      @(negedge clk);
      #2;
      check("pre_reset_valid", {31'b0, valid_out}, 32'd1);
      reset = 1'b1;
      #1;
      check("async_reset_valid", {31'b0, valid_out}, 32'd0);
      check("async_reset_instr", instr_out, NOP_INSTR);
      check("async_reset_pc", pc_out, RPC);
      mem_q.delete();
      imem_rvalid_in = 1'b0;
      repeat (2) cycle();
      reset   = 1'b0;
      stl_pct = 0;
      repeat (10) cycle();
      rdy_pct = 70;
      rsp_pct = 60;
      stl_pct = 30;
      rdr_pct = 3;
      repeat (3000) cycle();
      rdy_pct = 100;
      rsp_pct = 100;
      stl_pct = 0;
      rdr_pct = 0;
      repeat (20) cycle();
      check("drain_bound", {31'b0, (exp_q.size() <= D)}, 32'd1);
      check("deliveries_seen", {31'b0, (n_pops > 500)}, 32'd1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   logic        prev_valid = 1'b0;
   logic        prev_stall = 1'b0;
   logic        prev_redirect = 1'b0;
   logic        prev_ivalid = 1'b0;
   logic        prev_ready = 1'b0;
   logic [31:0] prev_pc = 32'h0;
   logic [31:0] prev_instr = 32'h0;

   // Monitor: observes the DUT away from the rising edge, records accepts for
   // the memory and pops/compares the scoreboard on every delivered instruction.
   always @(negedge clk) begin
      logic        acc;
      logic [63:0] e;
      if (reset) begin
         check("reset_valid", {31'b0, valid_out}, 32'd0);
         check("reset_instr", instr_out, NOP_INSTR);
         check("reset_pc", pc_out, RPC);
         check("reset_imem_valid", {31'b0, imem_valid_out}, 32'd0);
         exp_q.delete();
         req_pc        = RPC;
         cyc           = 0;
         prev_valid    = 1'b0;
         prev_stall    = 1'b0;
         prev_redirect = 1'b0;
         prev_ivalid   = 1'b0;
         prev_ready    = 1'b0;
      end else begin
         cyc++;
         if (zw && cyc < 3) check("startup_not_valid", {31'b0, valid_out}, 32'd0);
         if (zw && cyc >= 3 && cyc <= 14) check("stream_valid", {31'b0, valid_out}, 32'd1);
         if (full_chk) begin
            check("full_no_issue", {31'b0, imem_valid_out}, 32'd0);
            check("full_valid", {31'b0, valid_out}, 32'd1);
         end
         if (redirect_in) check("no_issue_on_redirect", {31'b0, imem_valid_out}, 32'd0);
         if (prev_redirect) check("empty_after_redirect", {31'b0, valid_out}, 32'd0);
         if (prev_ivalid && !prev_ready && !prev_redirect && !redirect_in)
            check("req_held", {31'b0, imem_valid_out}, 32'd1);
         if (prev_valid && prev_stall && !prev_redirect) begin
            check("stall_valid", {31'b0, valid_out}, 32'd1);
            check("stall_pc", pc_out, prev_pc);
            check("stall_instr", instr_out, prev_instr);
         end
         if (!valid_out) check("empty_nop", instr_out, NOP_INSTR);
         if (imem_valid_out) check("req_addr", imem_addr_out, req_pc);
         acc = imem_valid_out && imem_ready_in;
         if (acc) mem_q.push_back(imem_addr_out);
         if (redirect_in) begin
            exp_q.delete();
            req_pc = redirect_pc_in & 32'hFFFF_FFFC;
         end else begin
            if (valid_out && !stall_in) begin
               n_pops++;
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL unexpected_output: got pc %h with nothing expected", pc_out);
               end else begin
                  e = exp_q.pop_front();
                  check("out_pc", pc_out, e[63:32]);
                  check("out_instr", instr_out, e[31:0]);
               end
            end
            if (acc) begin
               exp_q.push_back({req_pc, mem_word(req_pc)});
               req_pc = req_pc + 32'd4;
            end
         end
         prev_valid    = valid_out;
         prev_stall    = stall_in;
         prev_redirect = redirect_in;
         prev_ivalid   = imem_valid_out;
         prev_ready    = imem_ready_in;
         prev_pc       = pc_out;
         prev_instr    = instr_out;
      end
   end

endmodule

// File: doc/fetch.md
# fetch

Instruction fetch stage of the RISC-V pipeline, the producer side of the decode stage's `instr_in`/`pc_in_dec` interface. It owns the program counter and issues in-order word reads to instruction memory over a valid/ready request channel with a separate response channel. It buffers returned instructions in a small FIFO and hands them to decode under decode's stall signal. A redirect from execute, caused by a taken branch or jump, restarts fetch at a new PC and discards all older instructions.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `DEPTH`, default 2: FIFO entries; this is also the maximum number of requests in flight plus buffered instructions. Legal values are 2–8.

Ports:
- `req`, in, 1: pipeline clock; all state changes on its rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `stall_in`, in, 1: decode is not accepting (decode's `rs_read`). The head is held while it is high.
- `redirect_in`, in, 1: taken branch or jump from execute.
- `redirect_pc_in`, in, 32: new fetch PC; bits [1:0] are ignored and forced to 0.
- `imem_valid_out`, out, 1: request valid.
- `imem_addr_out`, out, 32: request word address, always equal to the PC register.
- `imem_ready_in`, in, 1: memory accepts the request.
- `imem_rvalid_in`, in, 1: response valid; responses return in order, at least one cycle after acceptance.
- `imem_rdata_in`, in, 32: instruction word.
- `valid_out`, out, 1: `instr_out`/`pc_out` hold a live instruction.
- `instr_out`, out, 32: instruction to decode `instr_in`.
- `pc_out`, out, 32: its address, to decode `pc_in_dec`.

## Operation
- Request handshake: a request is accepted when `imem_valid_out && imem_ready_in`. On acceptance, PC <= PC+4 (wrapping modulo 2^32) and `outstanding` += 1.
- Each accepted request pushes its PC into an internal in-order address queue, so every response is paired with its address.
- Credit rule: `imem_valid_out` = !`redirect_in` && (`outstanding` + `occupancy` − `pop`) < `DEPTH`. Here `pop` = `valid_out && !stall_in`. A pop frees a credit in the same cycle.
- `imem_valid_out` may drop without a handshake only in a cycle where `redirect_in` is high. Otherwise, once asserted, the request and address are held until accepted.
- Response: on `imem_rvalid_in`, `outstanding` −= 1. If `drop_cnt` = 0, the pair {instruction, PC} is pushed into the FIFO. If `drop_cnt` > 0, the response is discarded and `drop_cnt` −= 1.
- Output: `valid_out` = FIFO non-empty. `instr_out`/`pc_out` are the head entry. When the FIFO is empty, `instr_out` = NOP 32'h0000_0013 and `pc_out` = last popped PC.
- Redirect has priority over stall, push and issue:
  - PC <= {redirect_pc_in[31:2], 2'b00}.
  - FIFO cleared.
  - `drop_cnt` <= `outstanding` after this cycle's accept and return are accounted, i.e. `outstanding` + accepted − returned.
  - A response returning in the redirect cycle is discarded.
- Counters are sized to `$clog2(DEPTH)+1` bits. `outstanding` + `occupancy` never exceeds `DEPTH`, so the FIFO never overflows. A response arriving while `outstanding` = 0 is a protocol error; the bench asserts it never occurs.

## Timing
- Reset values: PC = `RESET_PC`, `outstanding` = 0, `drop_cnt` = 0, FIFO empty, `valid_out` = 0, `instr_out` = 32'h0000_0013, `pc_out` = `RESET_PC`, `imem_valid_out` = 0 while `reset` is high.
- First request: `imem_valid_out` rises in the first cycle after `reset` deasserts, with `imem_addr_out` = `RESET_PC`.
- Latency: a response in cycle N appears on `valid_out`/`instr_out` in cycle N+1.
- Throughput: with `DEPTH`=2 and zero-wait memory (response the cycle after accept), the stage sustains one instruction per cycle.
- Redirect in cycle N:
  - No request is issued in N.
  - `valid_out` = 0 in N+1.
  - `imem_addr_out` = redirect target with `imem_valid_out` = 1 in N+1, subject to credit.
- Stall: the head and `valid_out` are held stable for as long as `stall_in` = 1.
- Reset asserted mid-operation: all state clears immediately (asynchronous). Responses still in flight afterwards are the memory's responsibility to squash.

## Structure
- Shared package `riscv_pkg`:
  - `NOP_INSTR` = 32'h0000_0013.
  - `XLEN` = 32.
  - The opcode constants already used by decode (R/I/U/B/J/S types).
- Sub-module `fetch_fifo`: parameterised `DEPTH`-entry synchronous FIFO of {pc, instr} with push, pop and flush, plus count and empty outputs, reused for the in-flight address queue.
- Top level: PC register, credit logic, `outstanding`/`drop_cnt` counters, redirect muxing.

## Test plan
- Reset release, `RESET_PC`=0x100, zero-wait memory returning `addi` words → requests to 0x100, 0x104, 0x108…; `valid_out` from cycle 3 onward, with `pc_out` incrementing by 4 every cycle.
- `stall_in` held high for 5 cycles with the FIFO full → `imem_valid_out` = 0, and the head stays at the same `pc_out`/`instr_out`. On release, fetch resumes with no gap and no duplicate.
- Redirect to 0x2002 with 2 requests in flight → both responses dropped; next `valid_out` shows `pc_out` = 0x2000; no stale PC is ever output.
- Redirect in the same cycle as `imem_rvalid_in` and a stall → that response is dropped, the FIFO is empty next cycle, and the next address is the target.
- PC at 0xFFFF_FFFC → following request address is 0x0000_0000.
- `reset` asserted asynchronously mid-stream with 2 buffered instructions → `valid_out` = 0 and `instr_out` = 0x0000_0013 before the next clock edge; after release, fetch restarts at `RESET_PC`.
